mux_feed_arbiter: RTL

MUX_FEED_ARBITER -- requirements
Module: mux_feed_arbiter

---
 rtl/mux_feed_arbiter_pkg.sv | 6 +
 rtl/mux_feed_arbiter_rr_pick.sv | 24 ++
 rtl/mux_feed_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/mux_feed_arbiter_pkg.sv
// mux_feed_arbiter_pkg: shared FSM state type and channel/select widths for the feed arbiter.
package mux_feed_arbiter_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W = 2;
    typedef enum logic [1:0] {IDLE, PRESENT, DROP} state_e;
endpackage

// File: rtl/mux_feed_arbiter_rr_pick.sv
// rr_pick: first pending channel at or after ptr, wrapping modulo NUM_CH.
module rr_pick
    import mux_feed_arbiter_pkg::*;
(
    input  logic [0:NUM_CH-1] pending,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);
    logic [SEL_W-1:0] c;
    // Scan farthest-first so the nearest pending channel is the last to win.
    always_comb begin
        found = 1'b0;
        idx = ptr;
        c = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = ptr + SEL_W'(k);
            if (pending[c]) begin
                found = 1'b1;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/mux_feed_arbiter.sv
// mux_feed_arbiter: captures per-channel bits and presents pending channels round-robin
// to a downstream 4x1 mux, dropping a channel that waits TIMEOUT cycles for ready.
module mux_feed_arbiter
    import mux_feed_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [0:NUM_CH-1] req,
    input  logic [0:NUM_CH-1] din,
    output logic [SEL_W-1:0]  s,
    output logic [0:NUM_CH-1] d,
    output logic              valid,
    input  logic              ready,
    output logic [0:NUM_CH-1] pending,
    output logic              overrun,
    output logic              drop
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d, s_q, s_d, idx;
    logic [7:0]        cnt_q, cnt_d;
    logic [0:NUM_CH-1] hold_q, hold_d, pend_q, pend_d, clr;
    logic              valid_q, valid_d, overrun_q, overrun_d, drop_q, drop_d, found;
    rr_pick u_pick (
        .pending(pend_q),
        .ptr    (ptr_q),
        .found  (found),
        .idx    (idx)
    );
    // A release (accept or timeout) clears the presented channel; a coincident req re-sets it.
    always_comb begin
        state_d = state_q;
        s_d = s_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        clr = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = PRESENT;
                    s_d = idx;
                end
            end
            PRESENT: begin
                if (ready || cnt_q == LAST) begin
                    clr[s_q] = 1'b1;
                    ptr_d = s_q + 2'd1;
                    cnt_d = '0;
                    state_d = ready ? IDLE : DROP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d = (pend_q & ~clr) | req;
        hold_d = (hold_q & ~req) | (din & req);
        overrun_d = |(req & pend_q & ~clr);
        valid_d = state_d == PRESENT;
        drop_d = state_d == DROP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            cnt_q <= '0;
            hold_q <= '0;
            pend_q <= '0;
            s_q <= '0;
            valid_q <= 1'b0;
            overrun_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            hold_q <= hold_d;
            pend_q <= pend_d;
            s_q <= s_d;
            valid_q <= valid_d;
            overrun_q <= overrun_d;
            drop_q <= drop_d;
        end
    end
    assign s = s_q;
    assign d = hold_q;
    assign valid = valid_q;
    assign pending = pend_q;
    assign overrun = overrun_q;
    assign drop = drop_q;
endmodule
